// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//   Shared definitions for the memory-access stage: MIPS load/store opcode
//   constants, the data-bus size encoding, the stage FSM state type and two
//   small decode helpers used by both the stage and the lane aligner.
package mem_stage_pkg;

  // MIPS primary opcodes for the memory instructions handled by the stage.
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SWL = 6'h2A;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SWR = 6'h2E;
  localparam logic [5:0] OP_LL  = 6'h30;
  localparam logic [5:0] OP_SC  = 6'h38;

  // dreq_size encoding.
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } mem_state_t;

  // Bus transfer size for an opcode. LWL/LWR/SWL/SWR move a whole word and
  // rely on the merge / strobes to pick the bytes that matter.
  function automatic logic [1:0] op_size(input logic [5:0] op);
    logic [1:0] s;
    case (op)
      OP_LB, OP_LBU, OP_SB:  s = SIZE_BYTE;
      OP_LH, OP_LHU, OP_SH:  s = SIZE_HALF;
      default:               s = SIZE_WORD;
    endcase
    return s;
  endfunction

  // Natural-alignment violation for the ops that require it.
  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] a);
    logic m;
    case (op)
      OP_LH, OP_LHU, OP_SH:         m = a[0];
      OP_LW, OP_LL, OP_SW, OP_SC:   m = |a;
      default:                      m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// mem_stage_align
//   Purely combinational lane logic for the memory stage.
//   Loads : extracts / sign- or zero-extends the addressed byte or half, or
//           merges the returned word with the old rt value for LWL/LWR.
//   Stores: produces the byte strobes and lane-replicated / shifted data.
// Ports:
//   i_op         opcode of the latched instruction
//   i_addr_lo    low two address bits (byte offset within the word)
//   i_rt         store data, or old rt value for LWL/LWR
//   i_mem        word returned by the data bus
//   o_load_data  writeback value for loads
//   o_strobe     byte write enables (0 for loads)
//   o_store_data lane-positioned store data (0 for loads)
//   o_size       bus transfer size
module mem_stage_align
  import mem_stage_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rt,
  input  logic [31:0] i_mem,
  output logic [31:0] o_load_data,
  output logic [3:0]  o_strobe,
  output logic [31:0] o_store_data,
  output logic [1:0]  o_size
);

  logic [1:0]  w_b;        // effective byte offset
  logic [4:0]  w_sh;       // 8*b
  logic [4:0]  w_shc;      // 8*(3-b)
  logic [31:0] w_mem_sh;   // returned word shifted so the addressed lane is at bit 0
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Half/word ops ignore the offset bits they do not use. With the alignment
  // check enabled those bits are already zero by the time a request is made;
  // with it disabled this is what makes the misaligned access behave as the
  // aligned one.
  always_comb begin
    w_b = i_addr_lo;
    case (i_op)
      OP_LH, OP_LHU, OP_SH:        w_b = {i_addr_lo[1], 1'b0};
      OP_LW, OP_LL, OP_SW, OP_SC:  w_b = 2'b00;
      default:                     w_b = i_addr_lo;
    endcase
  end

  assign w_sh     = {w_b, 3'b000};
  assign w_shc    = {~w_b, 3'b000};
  assign w_mem_sh = i_mem >> w_sh;
  assign w_byte   = w_mem_sh[7:0];
  assign w_half   = w_mem_sh[15:0];

  always_comb begin
    o_load_data = i_mem;
    case (i_op)
      OP_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_load_data = {24'd0, w_byte};
      OP_LH:   o_load_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_load_data = {16'd0, w_half};
      // LWL fills the upper bytes from memory, keeps the low bytes of rt.
      OP_LWL:  o_load_data = (i_mem << w_shc) | (i_rt & ~(32'hFFFF_FFFF << w_shc));
      // LWR fills the lower bytes from memory, keeps the high bytes of rt.
      OP_LWR:  o_load_data = (i_mem >> w_sh) | (i_rt & ~(32'hFFFF_FFFF >> w_sh));
      default: o_load_data = i_mem;
    endcase
  end

  always_comb begin
    o_strobe     = 4'h0;
    o_store_data = 32'd0;
    case (i_op)
      OP_SB: begin
        o_strobe     = 4'b0001 << w_b;
        o_store_data = {4{i_rt[7:0]}};
      end
      OP_SH: begin
        o_strobe     = 4'b0011 << w_b;
        o_store_data = {2{i_rt[15:0]}};
      end
      OP_SW, OP_SC: begin
        o_strobe     = 4'hF;
        o_store_data = i_rt;
      end
      OP_SWL: begin
        o_strobe     = 4'hF >> (~w_b);
        o_store_data = i_rt >> w_shc;
      end
      OP_SWR: begin
        o_strobe     = 4'hF << w_b;
        o_store_data = i_rt << w_sh;
      end
      default: begin
        o_strobe     = 4'h0;
        o_store_data = 32'd0;
      end
    endcase
  end

  assign o_size = op_size(i_op);

endmodule

// File: rtl/mem_stage.sv
// mem_stage
//   Memory-access stage of the 5-stage MIPS pipeline. Accepts the execute
//   bundle, checks alignment, runs the data-bus handshake for loads/stores,
//   keeps the LL/SC link bit and registers the writeback bundle.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   in_valid / in_ready         execute bundle handshake
//   in_op, in_rm, in_wm         opcode, load marker, store marker
//   in_addr, in_data            effective address / ALU value, store data or old rt
//   in_regw, in_pc, in_exc      destination reg, PC, upstream exception flag
//   eret                        ERET committed (clears the link bit)
//   dreq_*                      data bus request (valid, addr, size, strobe, data)
//   dresp_*                     data bus response (addr_ok, data_ok, data)
//   stall                       freezes upstream stages
//   out_*                       writeback bundle (out_valid is a one-cycle pulse)
//   dbg_state                   current FSM state
//
// Bus handshake: in REQ, dreq_valid is high and all dreq_* fields are held
// constant until dresp_addr_ok. addr_ok together with data_ok completes the
// access in that cycle; addr_ok alone moves to WAIT, where dreq_valid is low
// and the access completes on data_ok. The writeback bundle appears on the
// cycle after completion.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ALLOW_MISALIGNED = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic        in_rm,
  input  logic        in_wm,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic [4:0]  in_regw,
  input  logic [31:0] in_pc,
  input  logic        in_exc,
  input  logic        eret,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [1:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data,
  output logic        stall,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [4:0]  out_regw,
  output logic [31:0] out_pc,
  output logic        out_adel,
  output logic        out_ades,
  output logic [31:0] out_badvaddr,
  output logic [1:0]  dbg_state
);

  mem_state_t  r_state;
  logic [5:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_rt;
  logic [4:0]  r_regw;
  logic [31:0] r_pc;
  logic        r_is_load;
  logic        r_llbit;

  logic        r_out_valid;
  logic [31:0] r_out_data;
  logic [4:0]  r_out_regw;
  logic [31:0] r_out_pc;
  logic        r_out_adel;
  logic        r_out_ades;
  logic [31:0] r_out_badvaddr;

  logic        w_accept;
  logic        w_is_mem;
  logic        w_misal;
  logic        w_addr_err;
  logic        w_sc_fail;
  logic        w_go_bus;
  logic        w_done;
  logic [31:0] w_load_data;
  logic [3:0]  w_strobe;
  logic [31:0] w_store_data;
  logic [1:0]  w_size;

  assign w_accept   = in_valid && (r_state == S_IDLE);
  assign w_is_mem   = in_rm || in_wm;
  assign w_misal    = (ALLOW_MISALIGNED == 0) && is_misaligned(in_op, in_addr[1:0]);
  // An upstream exception takes precedence over everything this stage checks.
  assign w_addr_err = w_is_mem && !in_exc && w_misal;
  // SC without a live link never reaches the bus.
  assign w_sc_fail  = w_is_mem && !in_exc && !w_misal && (in_op == OP_SC) && !r_llbit;
  assign w_go_bus   = w_accept && w_is_mem && !in_exc && !w_misal && !w_sc_fail;

  assign w_done = ((r_state == S_REQ)  && dresp_addr_ok && dresp_data_ok) ||
                  ((r_state == S_WAIT) && dresp_data_ok);

  mem_stage_align u_align (
    .i_op         (r_op),
    .i_addr_lo    (r_addr[1:0]),
    .i_rt         (r_rt),
    .i_mem        (dresp_data),
    .o_load_data  (w_load_data),
    .o_strobe     (w_strobe),
    .o_store_data (w_store_data),
    .o_size       (w_size)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_op           <= 6'd0;
      r_addr         <= 32'd0;
      r_rt           <= 32'd0;
      r_regw         <= 5'd0;
      r_pc           <= 32'd0;
      r_is_load      <= 1'b0;
      r_llbit        <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_data     <= 32'd0;
      r_out_regw     <= 5'd0;
      r_out_pc       <= 32'd0;
      r_out_adel     <= 1'b0;
      r_out_ades     <= 1'b0;
      r_out_badvaddr <= 32'd0;
    end else begin
      r_out_valid <= 1'b0;

      // ERET wins over an LL completing in the same cycle.
      if (eret) begin
        r_llbit <= 1'b0;
      end else if (w_done && (r_op == OP_LL)) begin
        r_llbit <= 1'b1;
      end else if (w_done && (r_op == OP_SC)) begin
        r_llbit <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_go_bus) begin
            r_op      <= in_op;
            r_addr    <= in_addr;
            r_rt      <= in_data;
            r_regw    <= in_regw;
            r_pc      <= in_pc;
            r_is_load <= in_rm;
            r_state   <= S_REQ;
          end else if (w_accept) begin
            // Non-memory op, upstream exception, address error or failed SC.
            r_out_valid    <= 1'b1;
            r_out_data     <= w_sc_fail ? 32'd0 : in_addr;
            r_out_regw     <= w_addr_err ? 5'd0 : in_regw;
            r_out_pc       <= in_pc;
            r_out_adel     <= w_addr_err && in_rm;
            r_out_ades     <= w_addr_err && in_wm;
            r_out_badvaddr <= w_addr_err ? in_addr : 32'd0;
          end
        end
        S_REQ: begin
          if (dresp_addr_ok) begin
            r_state <= dresp_data_ok ? S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (dresp_data_ok) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_done) begin
        r_out_valid    <= 1'b1;
        r_out_data     <= r_is_load ? w_load_data :
                          ((r_op == OP_SC) ? 32'd1 : r_addr);
        r_out_regw     <= r_regw;
        r_out_pc       <= r_pc;
        r_out_adel     <= 1'b0;
        r_out_ades     <= 1'b0;
        r_out_badvaddr <= 32'd0;
      end
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign stall       = (r_state != S_IDLE) || w_go_bus;
  assign dreq_valid  = (r_state == S_REQ);
  assign dreq_addr   = {r_addr[31:2], 2'b00};
  assign dreq_size   = w_size;
  assign dreq_strobe = w_strobe;
  assign dreq_data   = w_store_data;

  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_regw     = r_out_regw;
  assign out_pc       = r_out_pc;
  assign out_adel     = r_out_adel;
  assign out_ades     = r_out_ades;
  assign out_badvaddr = r_out_badvaddr;
  assign dbg_state    = r_state;

endmodule
